// File: rtl/boot_loader_ctrl.sv
// Purpose: UART byte-stream boot loader; parses load blocks into imem/dmem word writes, then releases the core.
// Latency: write strobe with address/data one cycle after the 4th byte of a word is accepted.
// Backpressure: rx_ready is high in every state but RUN; rx_valid gaps simply stall the parser.
module boot_loader_ctrl #(
    parameter int          ADDR_W    = 14,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  GO_BYTE   = 8'hC3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_resetn,
    output logic              busy,
    output logic              err
);

    typedef enum logic [3:0] {
        IDLE, TGT, ADDR0, ADDR1, CNT0, CNT1, DATA, CSUM, RUN, ERR
    } state_t;

    state_t              state_q, state_d;
    logic                tgt_q, tgt_d;          // 0 = imem, 1 = dmem
    logic [7:0]          lo_q, lo_d;            // low byte of address or count
    logic [ADDR_W-1:0]   addr_q, addr_d;        // next word address to write
    logic [15:0]         cnt_q, cnt_d;          // words still to receive
    logic [23:0]         word_q, word_d;        // first three bytes of current word
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          csum_q, csum_d;
    logic                imem_we_q, imem_we_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                acc;

    assign rx_ready    = (state_q != RUN);
    assign acc         = rx_valid && rx_ready;
    assign imem_we     = imem_we_q;
    assign dmem_we     = dmem_we_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign core_resetn = (state_q == RUN);
    assign err         = (state_q == ERR);
    assign busy        = (state_q != IDLE) && (state_q != RUN) && (state_q != ERR);

    // Next-state and datapath: one accepted byte advances the parser by at most one step.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        lo_d       = lo_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d    = TGT;
                        csum_d     = 8'h00;
                        byte_idx_d = 2'd0;
                    end else if (rx_data == GO_BYTE) begin
                        state_d = RUN;
                    end
                end
                TGT: begin
                    if (rx_data[7:1] == 7'd0) begin
                        tgt_d   = rx_data[0];
                        state_d = ADDR0;
                    end else begin
                        state_d = ERR;
                    end
                end
                ADDR0: begin
                    lo_d    = rx_data;
                    state_d = ADDR1;
                end
                ADDR1: begin
                    addr_d  = ADDR_W'({rx_data, lo_q});
                    state_d = CNT0;
                end
                CNT0: begin
                    lo_d    = rx_data;
                    state_d = CNT1;
                end
                CNT1: begin
                    cnt_d      = {rx_data, lo_q};
                    byte_idx_d = 2'd0;
                    state_d    = ({rx_data, lo_q} == 16'd0) ? CSUM : DATA;
                end
                DATA: begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            wr_data_d = {rx_data, word_q};
                            wr_addr_d = addr_q;
                            imem_we_d = ~tgt_q;
                            dmem_we_d = tgt_q;
                            addr_d    = addr_q + ADDR_W'(1);
                            cnt_d     = cnt_q - 16'd1;
                            if (cnt_q == 16'd1) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
                CSUM: begin
                    state_d = (rx_data == csum_q) ? IDLE : ERR;
                end
                default: begin
                    // RUN and ERR are terminal until reset; bytes are dropped.
                end
            endcase
        end
    end

    // State register with synchronous active-low reset; reset also kills any pending strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            lo_q       <= 8'h00;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            word_q     <= 24'd0;
            byte_idx_q <= 2'd0;
            csum_q     <= 8'h00;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            lo_q       <= lo_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            imem_we_q  <= imem_we_d;
            dmem_we_q  <= dmem_we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Purpose: randomized + directed check of boot_loader_ctrl against a block-level loader model.
// Latency: model expects each word strobe one cycle after its 4th byte.
// Backpressure: bytes are offered with random idle gaps; RUN must refuse bytes.
module tb_boot_loader_ctrl;

    localparam int         AW   = 14;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] GO   = 8'hC3;

    logic          clk;
    logic          resetn;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic          dmem_we;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          core_resetn;
    logic          busy;
    logic          err;

    boot_loader_ctrl #(.ADDR_W(AW), .SYNC_BYTE(SYNC), .GO_BYTE(GO)) dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .dmem_we(dmem_we),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_resetn(core_resetn),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic          tgt;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        expq[$];   // writes the model still expects
    wr_t        wlog[$];   // writes the DUT actually made
    logic [7:0] dq[$];     // data bytes of the block being sent
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         chk_en = 0;
    bit         exp_busy, exp_err, exp_run;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle: write strobes must match the model's queue, status must match the model's mode.
    always @(negedge clk) begin
        if (chk_en) begin
            wr_t e;
            if (imem_we && dmem_we) chk("both_we", 1, 0);
            if (imem_we || dmem_we) begin
                wlog.push_back('{dmem_we, wr_addr, wr_data});
                chk("write_expected", (expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("wr_target", dmem_we, e.tgt);
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                end
            end
            chk("busy", busy, exp_busy);
            chk("err", err, exp_err);
            chk("core_resetn", core_resetn, exp_run);
            chk("rx_ready", rx_ready, !exp_run);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        expq.delete();
        exp_busy = 0;
        exp_err  = 0;
        exp_run  = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_go();
        send_byte(GO);
        if (!exp_err && !exp_busy) exp_run = 1;
    endtask

    // One load block from dq; csum_byte < 0 means send the correct XOR, abort_at >= 0 resets before that data byte.
    task automatic send_block(input logic [7:0] tgt, input logic [15:0] addr, input int cnt,
                              input int csum_byte, input int abort_at);
        logic [7:0]  cs;
        logic [7:0]  cb;
        logic [31:0] word;
        cs = 8'h00;
        send_byte(SYNC);
        exp_busy = 1;
        send_byte(tgt);
        if (tgt > 8'd1) begin
            exp_busy = 0;
            exp_err  = 1;
            return;
        end
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'(cnt));
        send_byte(8'(cnt >> 8));
        for (int w = 0; w < cnt; w++) begin
            word = {dq[4*w+3], dq[4*w+2], dq[4*w+1], dq[4*w]};
            for (int b = 0; b < 4; b++) begin
                if (4*w + b == abort_at) begin
                    do_reset();
                    return;
                end
                if (b == 3) expq.push_back('{tgt[0], AW'((int'(addr) + w) % (1 << AW)), word});
                cs = cs ^ dq[4*w+b];
                send_byte(dq[4*w+b]);
            end
        end
        cb = (csum_byte < 0) ? cs : 8'(csum_byte);
        send_byte(cb);
        exp_busy = 0;
        if (cb != cs) exp_err = 1;
    endtask

    task automatic fill_dq(input int nbytes);
        dq.delete();
        for (int i = 0; i < nbytes; i++) dq.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0]  tgt, g;
        logic [15:0] addr;
        int          cnt, cs, ab;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        do_reset();
        chk_en = 1;

        // Reset values
        chk("rst_imem_we", imem_we, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_core_resetn", core_resetn, 0);
        chk("rst_rx_ready", rx_ready, 1);

        // imem block of two words; XOR of the eight data bytes is 0x2A
        dq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wlog.delete();
        send_block(8'h00, 16'h0010, 2, 8'h2A, -1);
        idle(2);
        chk("a_nwrites", wlog.size(), 2);
        chk("a_w0_tgt", wlog[0].tgt, 0);
        chk("a_w0_addr", wlog[0].addr, 14'h0010);
        chk("a_w0_data", wlog[0].data, 32'h12345678);
        chk("a_w1_addr", wlog[1].addr, 14'h0011);
        chk("a_w1_data", wlog[1].data, 32'hDEADBEEF);
        chk("a_err", err, 0);
        chk("a_busy", busy, 0);

        // dmem block with a bad checksum: writes stay, then terminal error; GO ignored
        do_reset();
        wlog.delete();
        send_block(8'h01, 16'h0010, 2, 8'h00, -1);
        send_go();
        idle(2);
        chk("b_nwrites", wlog.size(), 2);
        chk("b_w0_tgt", wlog[0].tgt, 1);
        chk("b_w1_data", wlog[1].data, 32'hDEADBEEF);
        chk("b_err", err, 1);
        chk("b_core_resetn", core_resetn, 0);

        // Address wrap at the top of the 14-bit space
        do_reset();
        wlog.delete();
        fill_dq(8);
        send_block(8'h00, 16'h3FFF, 2, -1, -1);
        idle(2);
        chk("c_w0_addr", wlog[0].addr, 14'h3FFF);
        chk("c_w1_addr", wlog[1].addr, 14'h0000);

        // Stray byte then a bad target
        do_reset();
        wlog.delete();
        send_byte(8'hFF);
        send_block(8'h02, 16'h0000, 0, -1, -1);
        idle(2);
        chk("d_err", err, 1);
        chk("d_nwrites", wlog.size(), 0);

        // Empty block then GO; RUN refuses further bytes
        do_reset();
        wlog.delete();
        send_block(8'h00, 16'h0000, 0, 8'h00, -1);
        send_go();
        chk("e_core_resetn", core_resetn, 1);
        chk("e_rx_ready", rx_ready, 0);
        rx_valid = 1'b1;
        rx_data  = SYNC;
        idle(3);
        rx_valid = 1'b0;
        chk("e_busy", busy, 0);
        chk("e_nwrites", wlog.size(), 0);

        // Reset after the 2nd data byte aborts the block; a fresh block then loads
        do_reset();
        wlog.delete();
        fill_dq(8);
        send_block(8'h00, 16'h0020, 2, -1, 2);
        chk("f_busy", busy, 0);
        dq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_block(8'h01, 16'h0030, 1, -1, -1);
        idle(2);
        chk("f_nwrites", wlog.size(), 1);
        chk("f_w0_addr", wlog[0].addr, 14'h0030);
        chk("f_w0_data", wlog[0].data, 32'h44332211);

        // Random episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int blk = 0; blk < 4; blk++) begin
                repeat ($urandom_range(0, 2)) begin
                    g = 8'($urandom);
                    if (g == SYNC || g == GO) g = 8'h00;
                    send_byte(g);
                end
                tgt  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
                addr = 16'($urandom);
                cnt  = $urandom_range(0, 4);
                fill_dq(cnt * 4);
                cs = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 255)) : -1;
                ab = (cnt > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, cnt*4 - 1)) : -1;
                send_block(tgt, addr, cnt, cs, ab);
                if (exp_err) begin
                    send_byte(GO);
                    send_byte(SYNC);
                    break;
                end
            end
            idle(2);
            chk("queue_drained", expq.size(), 0);
            if (!exp_err && $urandom_range(0, 2) == 0) begin
                send_go();
                rx_valid = 1'b1;
                rx_data  = SYNC;
                idle(2);
                rx_valid = 1'b0;
            end
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
